// File: rtl/cache_2way_wb_if.sv
// Processor-side and block-memory-side signals of the two-way write-back cache.
// The slave modport is the cache; the master modport is the core/memory environment.
interface cache_2way_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_2way_wb.sv
// Two-way set-associative write-back/write-allocate cache, 4-word blocks.
// Define CACHE_LRU_EN for per-set LRU replacement; otherwise the tag LSB picks the victim.
module cache_2way_wb #(
  parameter int SET_BITS = 2,
  parameter int TAG_W    = 28 - SET_BITS
) (
  input  logic           clk,
  input  logic           proc_reset,
  cache_2way_wb_if.slave bus
);
  localparam int NSETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;
  state_t state_q, state_d;

  logic [127:0]      data_q  [2][NSETS];
  logic [TAG_W-1:0]  tag_q   [2][NSETS];
  logic [1:0]        valid_q [NSETS];
  logic [1:0]        dirty_q [NSETS];
`ifdef CACHE_LRU_EN
  logic [NSETS-1:0]  lru_q;
`endif
  logic [27:0]       miss_addr_q;
  logic              victim_q;

  logic [SET_BITS-1:0] set_idx, mset;
  logic [TAG_W-1:0]    tag_in, mtag;
  logic [1:0]          word_idx;
  logic req, hit0, hit1, hit, hit_way, victim;
  logic rd_hit, wr_hit, miss_start, wb_done, fill_done;
  logic          stall, mrd, mwr;
  logic [31:0]   rdata;
  logic [27:0]   maddr;
  logic [127:0]  mwdata;

  assign set_idx  = bus.proc_addr[SET_BITS+1:2];
  assign tag_in   = bus.proc_addr[29:SET_BITS+2];
  assign word_idx = bus.proc_addr[1:0];
  assign mset     = miss_addr_q[SET_BITS-1:0];
  assign mtag     = miss_addr_q[27:SET_BITS];

  // Read and write together is treated as no request at all.
  assign req     = bus.proc_read ^ bus.proc_write;
  assign hit0    = valid_q[set_idx][0] && (tag_q[0][set_idx] == tag_in);
  assign hit1    = valid_q[set_idx][1] && (tag_q[1][set_idx] == tag_in);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;

  always_comb begin
    if (!valid_q[set_idx][0])      victim = 1'b0;
    else if (!valid_q[set_idx][1]) victim = 1'b1;
    else
`ifdef CACHE_LRU_EN
      victim = lru_q[set_idx];
`else
      victim = bus.proc_addr[SET_BITS+2];
`endif
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    rdata      = '0;
    mrd        = 1'b0;
    mwr        = 1'b0;
    maddr      = '0;
    mwdata     = '0;
    rd_hit     = 1'b0;
    wr_hit     = 1'b0;
    miss_start = 1'b0;
    wb_done    = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            rd_hit = bus.proc_read;
            wr_hit = bus.proc_write;
            if (bus.proc_read) rdata = data_q[hit_way][set_idx][{word_idx, 5'd0} +: 32];
          end else begin
            stall      = 1'b1;
            miss_start = 1'b1;
            state_d    = (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) ? WB : ALLOC;
          end
        end
      end
      WB: begin
        stall  = req;
        mwr    = 1'b1;
        maddr  = {tag_q[victim_q][mset], mset};
        mwdata = data_q[victim_q][mset];
        if (bus.mem_ready) begin
          wb_done = 1'b1;
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        stall = req;
        mrd   = 1'b1;
        maddr = miss_addr_q;
        if (bus.mem_ready) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.proc_stall = stall;
  assign bus.proc_rdata = rdata;
  assign bus.mem_read   = mrd;
  assign bus.mem_write  = mwr;
  assign bus.mem_addr   = maddr;
  assign bus.mem_wdata  = mwdata;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
`ifdef CACHE_LRU_EN
      lru_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (miss_start) victim_q <= victim;
      if (wr_hit) dirty_q[set_idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[mset][victim_q] <= 1'b0;
      if (fill_done) begin
        valid_q[mset][victim_q] <= 1'b1;
        dirty_q[mset][victim_q] <= 1'b0;
      end
`ifdef CACHE_LRU_EN
      if (rd_hit || wr_hit) lru_q[set_idx] <= ~hit_way;
`endif
    end
  end

  // Block storage and the latched miss address carry no reset.
  always_ff @(posedge clk) begin
    if (miss_start) miss_addr_q <= bus.proc_addr[29:2];
    if (wr_hit) data_q[hit_way][set_idx][{word_idx, 5'd0} +: 32] <= bus.proc_wdata;
    if (fill_done) begin
      data_q[victim_q][mset] <= bus.mem_rdata;
      tag_q[victim_q][mset]  <= mtag;
    end
  end
endmodule

// File: tb/tb_cache_2way_wb.sv
// Self-checking bench for cache_2way_wb: directed scenarios plus random traffic
// compared against a transaction-level cache/memory model.
module tb_cache_2way_wb;
  logic clk = 1'b0;
  logic proc_reset;
  int   checks = 0;
  int   failures = 0;

  cache_2way_wb_if bus ();
  cache_2way_wb #(.SET_BITS(2)) dut (.clk(clk), .proc_reset(proc_reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference state: resident blocks per set/way, recency per set, backing memory.
  logic [127:0] mdata  [2][4];
  logic [25:0]  mtag   [2][4];
  bit           mval   [2][4];
  bit           mdirty [2][4];
  int           mru    [4];
  logic [127:0] mainmem [logic [27:0]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 4; s++) begin
        mval[w][s]   = 1'b0;
        mdirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 4; s++) mru[s] = 1;
  endfunction

  function automatic logic [127:0] mem_blk(input logic [27:0] ba);
    if (!mainmem.exists(ba)) mainmem[ba] = {$urandom, $urandom, $urandom, $urandom};
    return mainmem[ba];
  endfunction

  function automatic int lookup(input int s, input logic [25:0] t);
    for (int w = 0; w < 2; w++)
      if (mval[w][s] && mtag[w][s] == t) return w;
    return -1;
  endfunction

  function automatic int pick_victim(input int s, input logic [29:0] a);
    if (!mval[0][s]) return 0;
    if (!mval[1][s]) return 1;
`ifdef CACHE_LRU_EN
    return 1 - mru[s];
`else
    return int'(a[4]);
`endif
  endfunction

  task automatic idle_check(input string tag);
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    @(negedge clk);
    chk({tag, "_stall"}, bus.proc_stall, 1'b0);
    chk({tag, "_rdata"}, bus.proc_rdata, 32'h0);
    chk({tag, "_mrd"},   bus.mem_read, 1'b0);
    chk({tag, "_mwr"},   bus.mem_write, 1'b0);
    chk({tag, "_maddr"}, bus.mem_addr, 28'h0);
    chk({tag, "_mwdat"}, bus.mem_wdata, 128'h0);
    cyc();
  endtask

  // One processor access, held until it completes; memory responds after lat cycles.
  task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd, input int lat);
    int s, w, v;
    logic [1:0]   sb;
    logic [25:0]  t;
    logic [127:0] blk, line;
    sb = a[3:2];
    s  = int'(sb);
    t  = a[29:4];
    bus.proc_read  = !wr;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = wd;
    w = lookup(s, t);
    if (w < 0) begin
      v = pick_victim(s, a);
      @(negedge clk);
      chk("miss_stall", bus.proc_stall, 1'b1);
      chk("miss_memidle", {bus.mem_read, bus.mem_write}, 2'b00);
      cyc();
      if (mval[v][s] && mdirty[v][s]) begin
        for (int i = 0; i < lat; i++) begin
          bus.mem_ready = (i == lat - 1);
          @(negedge clk);
          chk("wb_write", bus.mem_write, 1'b1);
          chk("wb_read", bus.mem_read, 1'b0);
          chk("wb_addr", bus.mem_addr, {mtag[v][s], sb});
          chk("wb_data", bus.mem_wdata, mdata[v][s]);
          chk("wb_stall", bus.proc_stall, 1'b1);
          cyc();
        end
        bus.mem_ready = 1'b0;
        mainmem[{mtag[v][s], sb}] = mdata[v][s];
        mdirty[v][s] = 1'b0;
      end
      blk = mem_blk(a[29:2]);
      for (int i = 0; i < lat; i++) begin
        bus.mem_ready = (i == lat - 1);
        bus.mem_rdata = blk;
        @(negedge clk);
        chk("alloc_read", bus.mem_read, 1'b1);
        chk("alloc_write", bus.mem_write, 1'b0);
        chk("alloc_addr", bus.mem_addr, a[29:2]);
        chk("alloc_stall", bus.proc_stall, 1'b1);
        cyc();
      end
      bus.mem_ready = 1'b0;
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mdata[v][s]  = blk;
      mtag[v][s]   = t;
      mval[v][s]   = 1'b1;
      mdirty[v][s] = 1'b0;
      w = v;
    end
    @(negedge clk);
    chk("hit_stall", bus.proc_stall, 1'b0);
    chk("hit_memidle", {bus.mem_read, bus.mem_write}, 2'b00);
    line = mdata[w][s];
    if (!wr) chk("hit_rdata", bus.proc_rdata, line[32*a[1:0] +: 32]);
    cyc();
    if (wr) begin
      line[32*a[1:0] +: 32] = wd;
      mdata[w][s]  = line;
      mdirty[w][s] = 1'b1;
    end
    mru[s] = w;
  endtask

  initial begin
    int v;
    logic [29:0] ra;
    proc_reset     = 1'b1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    model_reset();
    mainmem[28'h4] = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h11111111, 32'h01234567};
    #12;
    chk("rst_stall", bus.proc_stall, 1'b0);
    chk("rst_rdata", bus.proc_rdata, 32'h0);
    chk("rst_mrd", bus.mem_read, 1'b0);
    chk("rst_mwr", bus.mem_write, 1'b0);
    chk("rst_maddr", bus.mem_addr, 28'h0);
    chk("rst_mwdat", bus.mem_wdata, 128'h0);
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    idle_check("idle0");

    // Clean miss with a 3-cycle memory, then fill the sibling way of set 0.
    access(1'b0, 30'h11, 32'h0, 3);
    access(1'b0, 30'h00, 32'h0, 2);
    for (int i = 0; i < 10; i++) access(1'b0, (i % 2) ? 30'h10 : 30'h00, 32'h0, 1);

    // Replacement choice on a full set.
    access(1'b0, 30'h00, 32'h0, 1);
    access(1'b0, 30'h10, 32'h0, 1);
    access(1'b0, 30'h00, 32'h0, 1);
    access(1'b0, 30'h20, 32'h0, 2);
    access(1'b0, 30'h00, 32'h0, 1);
    access(1'b0, 30'h10, 32'h0, 1);

    // Dirty eviction: write-back runs straight into the allocation.
    access(1'b0, 30'h00, 32'h0, 1);
    access(1'b1, 30'h00, 32'hDEADBEEF, 1);
    access(1'b0, 30'h10, 32'h0, 1);
    access(1'b0, 30'h20, 32'h0, 3);
    access(1'b0, 30'h00, 32'h0, 2);

    // Read and write asserted together must be ignored.
    access(1'b0, 30'h10, 32'h0, 1);
    bus.proc_read  = 1'b1;
    bus.proc_write = 1'b1;
    bus.proc_addr  = 30'h10;
    bus.proc_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ill_stall", bus.proc_stall, 1'b0);
      chk("ill_rdata", bus.proc_rdata, 32'h0);
      chk("ill_mem", {bus.mem_read, bus.mem_write}, 2'b00);
      cyc();
    end
    access(1'b0, 30'h10, 32'h0, 1);
    idle_check("idle1");

    // Random traffic over six tags per set, so sets thrash and lines go dirty.
    for (int n = 0; n < 150; n++) begin
      ra = {26'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) idle_check("idle_r");
    end

    // Reset during the allocation phase of a miss.
    access(1'b0, 30'h00, 32'h0, 1);
    ra = 30'h3F4;
    v  = pick_victim(1, ra);
    bus.proc_read = 1'b1;
    bus.proc_addr = ra;
    @(negedge clk);
    chk("rmiss_stall", bus.proc_stall, 1'b1);
    cyc();
    if (mval[v][1] && mdirty[v][1]) begin
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("rwb_write", bus.mem_write, 1'b1);
      cyc();
      bus.mem_ready = 1'b0;
      mainmem[{mtag[v][1], 2'b01}] = mdata[v][1];
    end
    @(negedge clk);
    chk("ralloc_read", bus.mem_read, 1'b1);
    #1;
    proc_reset = 1'b1;
    #1;
    chk("rst_mid_mrd", bus.mem_read, 1'b0);
    chk("rst_mid_mwr", bus.mem_write, 1'b0);
    chk("rst_mid_maddr", bus.mem_addr, 28'h0);
    bus.proc_read = 1'b0;
    model_reset();
    cyc();
    cyc();
    proc_reset = 1'b0;
    idle_check("idle2");
    access(1'b0, 30'h00, 32'h0, 2);
    access(1'b0, 30'h02, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
